// File: rtl/mem_wb_stage.sv
// mem_wb_stage: elastic MEM/WB pipeline register with valid/ready handshake,
// flush, writeback-data mux, forwarding tap and retired-instruction counter.
// Optional feature macro: MEMWB_SKID_EN (adds a second skid entry so that
// in_ready is registered and carries no combinational path from out_ready).
module mem_wb_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_load_data,
    input  logic [XLEN-1:0] in_alu_res,
    input  logic [REGW-1:0] in_rd,
    input  logic            in_wb_en,
    input  logic            in_mem_to_reg,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_load_data,
    output logic [XLEN-1:0] out_alu_res,
    output logic [REGW-1:0] out_rd,
    output logic            out_wb_en,
    output logic [XLEN-1:0] out_wb_data,
    output logic            fwd_valid,
    output logic [REGW-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic [CNTW-1:0] retired
);

    // Entry layout: {load_data, alu_res, rd, wb_en, mem_to_reg}
    localparam int EW = 2 * XLEN + REGW + 2;

    logic [EW-1:0]   in_entry;
    logic [EW-1:0]   head_reg;
    logic [EW-1:0]   head_next;
    logic            head_valid_reg;
    logic            head_valid_next;
    logic            head_wb_en;
    logic            head_mem_to_reg;
    logic [CNTW-1:0] retired_reg;
    logic            accept;
    logic            retire;

    // x0 is never written, so its write enable is dropped on capture
    assign in_entry = {in_load_data, in_alu_res, in_rd,
                       in_wb_en & (in_rd != '0), in_mem_to_reg};

    assign retire = head_valid_reg & out_ready;
    // A flush cycle discards whatever is offered on the input side
    assign accept = in_valid & in_ready & ~flush;

`ifdef MEMWB_SKID_EN
    logic [EW-1:0] skid_reg;
    logic [EW-1:0] skid_next;
    logic          skid_valid_reg;
    logic          skid_valid_next;

    // Ready depends only on skid occupancy (a flop), never on out_ready
    assign in_ready = ~rst & ~skid_valid_reg;

    // Two-entry FIFO: retire shifts skid into head, accept fills first free slot
    always_comb begin
        head_next       = head_reg;
        head_valid_next = head_valid_reg;
        skid_next       = skid_reg;
        skid_valid_next = skid_valid_reg;
        if (flush) begin
            head_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else begin
            if (retire) begin
                head_next       = skid_reg;
                head_valid_next = skid_valid_reg;
                skid_valid_next = 1'b0;
            end
            if (accept) begin
                if (!head_valid_next) begin
                    head_next       = in_entry;
                    head_valid_next = 1'b1;
                end else begin
                    skid_next       = in_entry;
                    skid_valid_next = 1'b1;
                end
            end
        end
    end

    // Skid entry register
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_reg       <= '0;
            skid_valid_reg <= 1'b0;
        end else begin
            skid_reg       <= skid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end
`else
    // Single entry: can take a new instruction whenever the head leaves
    assign in_ready = ~rst & (~head_valid_reg | out_ready);

    // Single-entry next state: accept (possibly replacing a retiring head) or drain
    always_comb begin
        head_next       = head_reg;
        head_valid_next = head_valid_reg;
        if (flush) begin
            head_valid_next = 1'b0;
        end else if (accept) begin
            head_next       = in_entry;
            head_valid_next = 1'b1;
        end else if (retire) begin
            head_valid_next = 1'b0;
        end
    end
`endif

    // Head entry register; data is cleared on reset so outputs read 0
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg       <= '0;
            head_valid_reg <= 1'b0;
        end else begin
            head_reg       <= head_next;
            head_valid_reg <= head_valid_next;
        end
    end

    // Retire counter: counts every output handshake, including on flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_reg <= '0;
        end else if (retire) begin
            retired_reg <= retired_reg + CNTW'(1);
        end
    end

    assign {out_load_data, out_alu_res, out_rd, head_wb_en, head_mem_to_reg} = head_reg;

    assign out_valid   = head_valid_reg;
    assign out_wb_en   = head_wb_en & head_valid_reg;
    assign out_wb_data = head_mem_to_reg ? out_load_data : out_alu_res;
    assign fwd_valid   = out_wb_en;
    assign fwd_rd      = out_rd;
    assign fwd_data    = out_wb_data;
    assign retired     = retired_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage (CNTW=4 so the retire
// counter wraps quickly). A negedge monitor models occupancy, checks the head
// entry against the queue and pops it on each output handshake; scenario
// tasks add targeted checks.
module tb_mem_wb_stage;

`ifdef MEMWB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_load_data;
    logic [31:0] in_alu_res;
    logic [4:0]  in_rd;
    logic        in_wb_en;
    logic        in_mem_to_reg;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_load_data;
    logic [31:0] out_alu_res;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic [31:0] out_wb_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [3:0]  retired;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] ld;
        logic [31:0] alu;
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        wb_en;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] ret_cnt = '0;

    mem_wb_stage #(.XLEN(32), .REGW(5), .CNTW(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_load_data(in_load_data), .in_alu_res(in_alu_res),
        .in_rd(in_rd), .in_wb_en(in_wb_en), .in_mem_to_reg(in_mem_to_reg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_load_data(out_load_data), .out_alu_res(out_alu_res),
        .out_rd(out_rd), .out_wb_en(out_wb_en), .out_wb_data(out_wb_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: sampled 2 ns after negedge, 3 ns before the next posedge
    always @(negedge clk) begin
        exp_t e;
        logic exp_rdy;
        logic acc;
        logic ret;
        #2;
        if (rst) begin
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL sb_in_ready_rst: got %b want 0", in_ready);
            else n_pass++;
            sb.delete();
            ret_cnt = '0;
        end else begin
            exp_rdy = SKID ? (sb.size() < 2) : (sb.size() == 0 || out_ready);
            n_checks++;
            if (in_ready !== exp_rdy) $display("FAIL sb_in_ready: got %b want %b", in_ready, exp_rdy);
            else n_pass++;
            n_checks++;
            if (out_valid !== (sb.size() > 0)) $display("FAIL sb_out_valid: got %b want %b", out_valid, sb.size() > 0);
            else n_pass++;
            n_checks++;
            if (retired !== ret_cnt) $display("FAIL sb_retired: got %0d want %0d", retired, ret_cnt);
            else n_pass++;
            if (sb.size() > 0) begin
                e = sb[0];
                n_checks++;
                if ({out_wb_data, out_rd, out_wb_en, fwd_valid, fwd_rd, fwd_data, out_load_data, out_alu_res} !==
                    {e.wb_data, e.rd, e.wb_en, e.wb_en, e.rd, e.wb_data, e.ld, e.alu})
                    $display("FAIL sb_head: got data=%h rd=%0d we=%b fwd=%b ld=%h alu=%h want data=%h rd=%0d we=%b ld=%h alu=%h",
                             out_wb_data, out_rd, out_wb_en, fwd_valid, out_load_data, out_alu_res,
                             e.wb_data, e.rd, e.wb_en, e.ld, e.alu);
                else n_pass++;
            end
            ret = (sb.size() > 0) && (out_ready === 1'b1);
            acc = (in_valid === 1'b1) && exp_rdy && (flush !== 1'b1);
            if (ret) begin
                void'(sb.pop_front());
                ret_cnt = ret_cnt + 4'd1;
            end
            if (acc) begin
                e.ld      = in_load_data;
                e.alu     = in_alu_res;
                e.wb_data = in_mem_to_reg ? in_load_data : in_alu_res;
                e.rd      = in_rd;
                e.wb_en   = in_wb_en && (in_rd != 5'd0);
                sb.push_back(e);
            end
            if (flush === 1'b1) sb.delete();
        end
    end

    task automatic drv(input logic v, input logic [31:0] ld, input logic [31:0] alu,
                       input logic [4:0] rd, input logic we, input logic m2r);
        in_valid      = v;
        in_load_data  = ld;
        in_alu_res    = alu;
        in_rd         = rd;
        in_wb_en      = we;
        in_mem_to_reg = m2r;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drv(1'b1, 32'hDEAD, 32'hBEEF, 5'd1, 1'b1, 1'b0);
        repeat (2) begin
            @(negedge clk); #3;
            n_checks++;
            if ({out_valid, out_wb_data, retired, fwd_valid} !== 38'd0)
                $display("FAIL reset_hold: got valid=%b data=%h ret=%0d fwd=%b want all 0",
                         out_valid, out_wb_data, retired, fwd_valid);
            else n_pass++;
        end
        @(negedge clk); rst = 1'b0; drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0); #3;
        n_checks++;
        if ({out_valid, out_wb_data, out_load_data, out_alu_res, out_rd} !== 102'd0)
            $display("FAIL reset_release: got valid=%b data=%h ld=%h alu=%h rd=%0d want all 0",
                     out_valid, out_wb_data, out_load_data, out_alu_res, out_rd);
        else n_pass++;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        @(negedge clk); drv(1'b1, 32'h55, 32'h10, 5'd3, 1'b1, 1'b0); #3;
        @(negedge clk); drv(1'b1, 32'hAB, 32'h20, 5'd4, 1'b1, 1'b1); #3;
        n_checks++;
        if ({out_valid, out_wb_data} !== {1'b1, 32'h10})
            $display("FAIL stream_first: got valid=%b data=%h want 1 00000010", out_valid, out_wb_data);
        else n_pass++;
        @(negedge clk); drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0); #3;
        n_checks++;
        if ({out_valid, out_wb_data, out_rd} !== {1'b1, 32'hAB, 5'd4})
            $display("FAIL stream_second: got valid=%b data=%h rd=%0d want 1 000000ab 4", out_valid, out_wb_data, out_rd);
        else n_pass++;
        @(negedge clk); #3;
        n_checks++;
        if ({out_valid, retired} !== {1'b0, 4'd2})
            $display("FAIL stream_done: got valid=%b retired=%0d want 0 2", out_valid, retired);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        @(negedge clk); out_ready = 1'b0; drv(1'b1, 32'h0, 32'h100, 5'd5, 1'b1, 1'b0); #3;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready_a: got %b want 1", in_ready);
        else n_pass++;
        @(negedge clk); drv(1'b1, 32'h0, 32'h200, 5'd6, 1'b1, 1'b0); #3;
        n_checks++;
        if (in_ready !== SKID) $display("FAIL bp_ready_b: got %b want %b", in_ready, SKID);
        else n_pass++;
        @(negedge clk); drv(1'b1, 32'h0, 32'h300, 5'd7, 1'b1, 1'b0); #3;
        n_checks++;
        if ({in_ready, out_valid, out_wb_data, out_rd} !== {1'b0, 1'b1, 32'h100, 5'd5})
            $display("FAIL bp_stall: got rdy=%b valid=%b data=%h rd=%0d want 0 1 00000100 5",
                     in_ready, out_valid, out_wb_data, out_rd);
        else n_pass++;
        @(negedge clk); out_ready = 1'b1; drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0); #3;
        n_checks++;
        if ({out_valid, out_wb_data} !== {1'b1, 32'h100})
            $display("FAIL bp_drain_a: got valid=%b data=%h want 1 00000100", out_valid, out_wb_data);
        else n_pass++;
        @(negedge clk); #3;
        n_checks++;
        if ({out_valid, (out_valid ? out_wb_data : 32'h0)} !== {SKID, (SKID ? 32'h200 : 32'h0)})
            $display("FAIL bp_drain_b: got valid=%b data=%h want valid=%b", out_valid, out_wb_data, SKID);
        else n_pass++;
        @(negedge clk); #3;
        n_checks++;
        if ({out_valid, retired} !== {1'b0, (SKID ? 4'd4 : 4'd3)})
            $display("FAIL bp_done: got valid=%b retired=%0d want 0 %0d", out_valid, retired, SKID ? 4 : 3);
        else n_pass++;
    endtask

    task automatic test_x0();
        @(negedge clk); out_ready = 1'b0; drv(1'b1, 32'h0, 32'h77, 5'd0, 1'b1, 1'b0); #3;
        @(negedge clk); drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0); #3;
        n_checks++;
        if ({out_valid, out_wb_en, fwd_valid, out_wb_data} !== {1'b1, 1'b0, 1'b0, 32'h77})
            $display("FAIL x0_gate: got valid=%b we=%b fwd=%b data=%h want 1 0 0 00000077",
                     out_valid, out_wb_en, fwd_valid, out_wb_data);
        else n_pass++;
        @(negedge clk); out_ready = 1'b1; #3;
        @(negedge clk); out_ready = 1'b0; #3;
    endtask

    task automatic test_flush();
        logic [3:0] snap;
        @(negedge clk); out_ready = 1'b0; drv(1'b1, 32'h0, 32'h1, 5'd8, 1'b1, 1'b0); #3;
        @(negedge clk); drv(1'b1, 32'h0, 32'h2, 5'd9, 1'b1, 1'b0); #3;
        @(negedge clk); flush = 1'b1; drv(1'b1, 32'h0, 32'h3, 5'd10, 1'b1, 1'b0); #3;
        snap = ret_cnt;
        @(negedge clk); flush = 1'b0; drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0); #3;
        n_checks++;
        if ({out_valid, in_ready, retired} !== {1'b0, 1'b1, snap})
            $display("FAIL flush_clear: got valid=%b rdy=%b retired=%0d want 0 1 %0d",
                     out_valid, in_ready, retired, snap);
        else n_pass++;
        // Flush on a cycle that also retires: that retire still counts
        @(negedge clk); drv(1'b1, 32'h0, 32'h4, 5'd11, 1'b1, 1'b0); #3;
        snap = ret_cnt;
        @(negedge clk); drv(1'b1, 32'h0, 32'h5, 5'd12, 1'b1, 1'b0); out_ready = 1'b1; flush = 1'b1; #3;
        @(negedge clk); flush = 1'b0; out_ready = 1'b0; drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0); #3;
        n_checks++;
        if ({out_valid, retired} !== {1'b0, snap + 4'd1})
            $display("FAIL flush_retire: got valid=%b retired=%0d want 0 %0d", out_valid, retired, snap + 4'd1);
        else n_pass++;
    endtask

    task automatic test_wrap();
        @(negedge clk); rst = 1'b1; out_ready = 1'b1; #3;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk); rst = 1'b0;
            drv(1'b1, 32'(i * 3), 32'(i + 100), 5'(i), 1'b1, i[0]); #3;
        end
        @(negedge clk); drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0); #3;
        n_checks++;
        if (retired !== 4'd0) $display("FAIL wrap_16: got %0d want 0", retired);
        else n_pass++;
        @(negedge clk); #3;
        n_checks++;
        if ({out_valid, retired} !== {1'b0, 4'd1})
            $display("FAIL wrap_17: got valid=%b retired=%0d want 0 1", out_valid, retired);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_x0();
        test_flush();
        test_wrap();
        @(negedge clk); #4;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
